// File: rtl/shift_pkg.sv
// Shared types and constants for the iterative shifter.
// Optional feature macro: ITER_SHIFTER_STEP4_EN (greedy 4/2/1 step sizes).
package shift_pkg;

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned SHAMT_W = 5;
  localparam int unsigned STEP_W  = 3;

  localparam logic OP_SLL = 1'b0;
  localparam logic OP_SRA = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  // Largest permitted step that does not overshoot the remaining count.
  function automatic logic [STEP_W-1:0] step_size(input logic [SHAMT_W-1:0] rem);
    logic [STEP_W-1:0] s;
`ifdef ITER_SHIFTER_STEP4_EN
    if (rem >= SHAMT_W'(4)) begin
      s = STEP_W'(4);
    end else if (rem >= SHAMT_W'(2)) begin
      s = STEP_W'(2);
    end else begin
      s = STEP_W'(1);
    end
`else
    if (rem >= SHAMT_W'(2)) begin
      s = STEP_W'(2);
    end else begin
      s = STEP_W'(1);
    end
`endif
    return s;
  endfunction

endpackage

// File: rtl/shift_step.sv
// One combinational shift step: SLL zero-fills LSBs, SRA replicates bit 31.
module shift_step
  import shift_pkg::*;
(
  input  logic [DATA_W-1:0] value,
  input  logic              op,
  input  logic [STEP_W-1:0] step,
  output logic [DATA_W-1:0] shifted
);

  // Shift the value by the requested step in the latched direction.
  always_comb begin
    if (op == OP_SRA) begin
      shifted = $signed(value) >>> step;
    end else begin
      shifted = value << step;
    end
  end

endmodule

// File: rtl/iter_shifter.sv
// Iterative 32-bit shifter (SLL / SRA), one step per clock in SHIFT.
// Optional feature macro: ITER_SHIFTER_STEP4_EN (adds 4-bit steps).
module iter_shifter
  import shift_pkg::*;
(
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic               op,
  input  logic [DATA_W-1:0]  operand,
  input  logic [SHAMT_W-1:0] shamt,
  output logic [DATA_W-1:0]  result,
  output logic               ready,
  output logic               busy
);

  state_e              state_q;
  logic [DATA_W-1:0]   work_q;
  logic [SHAMT_W-1:0]  rem_q;
  logic                op_q;
  logic                ready_q;
  logic                busy_q;

  logic [STEP_W-1:0]   step_d;
  logic [DATA_W-1:0]   work_d;

  // Step size for the current remaining count.
  always_comb begin
    step_d = step_size(rem_q);
  end

  shift_step u_step (
    .value   (work_q),
    .op      (op_q),
    .step    (step_d),
    .shifted (work_d)
  );

  // Control FSM; ready/busy are registered alongside the state so they
  // track (state == DONE) / (state == SHIFT) exactly.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      work_q  <= '0;
      rem_q   <= '0;
      op_q    <= OP_SLL;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            work_q <= operand;
            rem_q  <= shamt;
            op_q   <= op;
            if (shamt != '0) begin
              state_q <= SHIFT;
              ready_q <= 1'b0;
              busy_q  <= 1'b1;
            end else begin
              state_q <= DONE;
              ready_q <= 1'b1;
              busy_q  <= 1'b0;
            end
          end else begin
            state_q <= IDLE;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
          end
        end
        SHIFT: begin
          work_q <= work_d;
          rem_q  <= rem_q - SHAMT_W'(step_d);
          if (rem_q == SHAMT_W'(step_d)) begin
            state_q <= DONE;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          ready_q <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign result = work_q;
  assign ready  = ready_q;
  assign busy   = busy_q;

endmodule

// File: tb/tb_iter_shifter.sv
// Self-checking bench for iter_shifter (honours ITER_SHIFTER_STEP4_EN).
module tb_iter_shifter;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        op = 1'b0;
  logic [31:0] operand = '0;
  logic [4:0]  shamt = '0;
  logic [31:0] result;
  logic        ready;
  logic        busy;

  int n_cmp = 0;
  int n_err = 0;

  iter_shifter dut (
    .clock   (clock),
    .reset   (reset),
    .start   (start),
    .op      (op),
    .operand (operand),
    .shamt   (shamt),
    .result  (result),
    .ready   (ready),
    .busy    (busy)
  );

  always #5 clock = ~clock;

  // Reference: the whole shift in one go.
  function automatic logic [31:0] ref_result(input logic o, input logic [31:0] a, input int s);
    logic signed [31:0] sa;
    sa = a;
    if (o) return sa >>> s;
    return a << s;
  endfunction

  // Reference: number of SHIFT cycles for a given amount.
  function automatic int ref_lat(input int s);
`ifdef ITER_SHIFTER_STEP4_EN
    return s / 4 + (s % 4) / 2 + s % 2;
`else
    return (s + 1) / 2;
`endif
  endfunction

  // Present one request; returns #1 after the acceptance edge.
  task automatic issue(input logic o, input logic [31:0] a, input logic [4:0] s);
    @(negedge clock);
    start = 1'b1; op = o; operand = a; shamt = s;
    @(posedge clock); #1;
    start = 1'b0;
  endtask

  // Count cycles until ready; busy must be high every cycle before it.
  task automatic wait_ready(output int lat, output logic [31:0] res, output int busy_bad);
    lat = -1; res = '0; busy_bad = 0;
    for (int k = 0; k < 40; k++) begin
      if (ready === 1'b1) begin
        lat = k; res = result;
        if (busy !== 1'b0) busy_bad++;
        break;
      end
      if (busy !== 1'b1) busy_bad++;
      @(posedge clock); #1;
    end
  endtask

  task automatic test_reset();
    #2;
    n_cmp++; if (result !== 32'h0) begin n_err++; $display("FAIL reset_result got=%h exp=%h", result, 32'h0); end
    n_cmp++; if (ready !== 1'b0) begin n_err++; $display("FAIL reset_ready got=%b exp=0", ready); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got=%b exp=0", busy); end
    @(negedge clock); reset = 1'b1;
  endtask

  task automatic test_sra_basic();
    int lat, bb; logic [31:0] r;
    issue(1'b1, 32'h8000_0000, 5'd2);
    wait_ready(lat, r, bb);
    n_cmp++; if (lat !== 1) begin n_err++; $display("FAIL sra2_latency got=%0d exp=1", lat); end
    n_cmp++; if (r !== 32'hE000_0000) begin n_err++; $display("FAIL sra2_result got=%h exp=e0000000", r); end
    n_cmp++; if (bb !== 0) begin n_err++; $display("FAIL sra2_busy got=%0d bad cycles exp=0", bb); end
    @(posedge clock); #1;
    n_cmp++; if (ready !== 1'b0) begin n_err++; $display("FAIL sra2_ready_pulse got=%b exp=0", ready); end
    n_cmp++; if (result !== 32'hE000_0000) begin n_err++; $display("FAIL sra2_hold got=%h exp=e0000000", result); end
  endtask

  task automatic test_sll_31();
    int lat, bb, exp_lat; logic [31:0] r;
`ifdef ITER_SHIFTER_STEP4_EN
    exp_lat = 9;
`else
    exp_lat = 16;
`endif
    issue(1'b0, 32'h0000_0001, 5'd31);
    wait_ready(lat, r, bb);
    n_cmp++; if (lat !== exp_lat) begin n_err++; $display("FAIL sll31_latency got=%0d exp=%0d", lat, exp_lat); end
    n_cmp++; if (r !== 32'h8000_0000) begin n_err++; $display("FAIL sll31_result got=%h exp=80000000", r); end
    n_cmp++; if (bb !== 0) begin n_err++; $display("FAIL sll31_busy got=%0d bad cycles exp=0", bb); end
  endtask

  task automatic test_shamt_zero();
    int lat, bb; logic [31:0] r;
    issue(1'b1, 32'h1234_ABCD, 5'd0);
    wait_ready(lat, r, bb);
    n_cmp++; if (lat !== 0) begin n_err++; $display("FAIL zero_latency got=%0d exp=0", lat); end
    n_cmp++; if (r !== 32'h1234_ABCD) begin n_err++; $display("FAIL zero_result got=%h exp=1234abcd", r); end
    n_cmp++; if (bb !== 0) begin n_err++; $display("FAIL zero_busy got=%0d bad cycles exp=0", bb); end
    @(posedge clock); #1;
    n_cmp++; if (busy !== 1'b0 || ready !== 1'b0) begin n_err++; $display("FAIL zero_after got busy=%b ready=%b exp 0/0", busy, ready); end
  endtask

  task automatic test_ignore_start();
    int lat, bb; logic [31:0] r;
    issue(1'b1, 32'h7FFF_FFF0, 5'd5);
    @(negedge clock);
    start = 1'b1; op = 1'b0; operand = 32'hFFFF_FFFF; shamt = 5'd0;
    @(posedge clock); #1;
    start = 1'b0;
    wait_ready(lat, r, bb);
    n_cmp++; if (lat !== ref_lat(5) - 1) begin n_err++; $display("FAIL ignore_latency got=%0d exp=%0d", lat, ref_lat(5) - 1); end
    n_cmp++; if (r !== 32'h03FF_FFFF) begin n_err++; $display("FAIL ignore_result got=%h exp=03ffffff", r); end
    n_cmp++; if (bb !== 0) begin n_err++; $display("FAIL ignore_busy got=%0d bad cycles exp=0", bb); end
    @(posedge clock); #1;
    n_cmp++; if (result !== 32'h03FF_FFFF || ready !== 1'b0) begin n_err++; $display("FAIL ignore_hold got=%h ready=%b exp 03ffffff/0", result, ready); end
  endtask

  task automatic test_reset_mid();
    int lat, bb, pulses; logic [31:0] r, a;
    a = $urandom;
    issue(1'b0, a, 5'd20);
    repeat (2) @(posedge clock);
    #3;
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL rstmid_busy_before got=%b exp=1", busy); end
    reset = 1'b0;
    #1;
    n_cmp++; if (ready !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL rstmid_flags got ready=%b busy=%b exp 0/0", ready, busy); end
    n_cmp++; if (result !== 32'h0) begin n_err++; $display("FAIL rstmid_result got=%h exp=00000000", result); end
    repeat (2) @(posedge clock);
    @(negedge clock); reset = 1'b1;
    pulses = 0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clock); #1;
      if (ready !== 1'b0) pulses++;
    end
    n_cmp++; if (pulses !== 0) begin n_err++; $display("FAIL rstmid_no_pulse got=%0d pulses exp=0", pulses); end
    a = $urandom;
    issue(1'b1, a, 5'd7);
    wait_ready(lat, r, bb);
    n_cmp++; if (lat !== ref_lat(7)) begin n_err++; $display("FAIL rstmid_after_latency got=%0d exp=%0d", lat, ref_lat(7)); end
    n_cmp++; if (r !== ref_result(1'b1, a, 7)) begin n_err++; $display("FAIL rstmid_after_result got=%h exp=%h", r, ref_result(1'b1, a, 7)); end
  endtask

  task automatic test_back_to_back();
    int lat, bb; logic [31:0] r, a;
    a = $urandom;
    issue(1'b1, a, 5'd3);
    wait_ready(lat, r, bb);
    n_cmp++; if (lat !== ref_lat(3) || r !== ref_result(1'b1, a, 3)) begin n_err++; $display("FAIL b2b_first got lat=%0d res=%h exp lat=%0d res=%h", lat, r, ref_lat(3), ref_result(1'b1, a, 3)); end
    // Still inside the DONE cycle: request the next op immediately.
    start = 1'b1; op = 1'b0; operand = 32'h0000_0003; shamt = 5'd1;
    @(posedge clock); #1;
    start = 1'b0;
    n_cmp++; if (busy !== 1'b1 || ready !== 1'b0) begin n_err++; $display("FAIL b2b_accept got busy=%b ready=%b exp 1/0", busy, ready); end
    @(posedge clock); #1;
    n_cmp++; if (ready !== 1'b1) begin n_err++; $display("FAIL b2b_ready got=%b exp=1", ready); end
    n_cmp++; if (result !== 32'h0000_0006) begin n_err++; $display("FAIL b2b_result got=%h exp=00000006", result); end
  endtask

  task automatic test_random();
    int lat, bb, s; logic [31:0] r, a; logic o;
    for (int i = 0; i < 60; i++) begin
      a = $urandom;
      o = 1'($urandom_range(0, 1));
      s = $urandom_range(0, 31);
      issue(o, a, 5'(s));
      wait_ready(lat, r, bb);
      n_cmp++; if (lat !== ref_lat(s)) begin n_err++; $display("FAIL rand_latency[%0d] op=%b shamt=%0d got=%0d exp=%0d", i, o, s, lat, ref_lat(s)); end
      n_cmp++; if (r !== ref_result(o, a, s)) begin n_err++; $display("FAIL rand_result[%0d] op=%b a=%h shamt=%0d got=%h exp=%h", i, o, a, s, r, ref_result(o, a, s)); end
      n_cmp++; if (bb !== 0) begin n_err++; $display("FAIL rand_busy[%0d] got=%0d bad cycles exp=0", i, bb); end
      if ($urandom_range(0, 1) == 1) begin
        @(posedge clock); #1;
      end
    end
  endtask

  initial begin
    test_reset();
    test_sra_basic();
    test_sll_31();
    test_shamt_zero();
    test_ignore_start();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/iter_shifter.md
ITER_SHIFTER -- requirements
Module: iter_shifter

Interface
REQ-001 The block SHALL have port clock, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-003 The block SHALL have port start, input, 1 bit: request a shift; sampled only when the block can accept.
REQ-004 The block SHALL have port op, input, 1 bit: 0 = SLL (logical left), 1 = SRA (arithmetic right); sampled with start.
REQ-005 The block SHALL have port operand, input, 32 bits: value to shift; sampled with start.
REQ-006 The block SHALL have port shamt, input, 5 bits: unsigned shift amount 0..31; sampled with start.
REQ-007 The block SHALL have port result, output, 32 bits: registered shift result; valid while ready=1, held afterwards until the next accepted start.
REQ-008 The block SHALL have port ready, output, 1 bit: one-cycle pulse marking result valid.
REQ-009 The block SHALL have port busy, output, 1 bit: high while an operation is in SHIFT state.

Function
REQ-010 The block SHALL implement states IDLE, SHIFT, DONE.
REQ-011 start SHALL be accepted in IDLE or DONE only; in SHIFT it SHALL be ignored, with no effect on the operation in flight.
REQ-012 On acceptance the block SHALL load operand into the working register, shamt into the remaining-count register and latch op; next state SHALL be SHIFT if shamt != 0, else DONE.
REQ-013 In SHIFT, each cycle SHALL perform one step: shift by 2 if remaining >= 2, else by 1; remaining decreases by the step size.
REQ-014 SRA steps SHALL replicate bit 31 into vacated MSBs; SLL steps SHALL fill vacated LSBs with 0.
REQ-015 When remaining reaches 0 after a step, next state SHALL be DONE.
REQ-016 With N = ceil(shamt/2) steps, and start accepted at edge t0, DONE SHALL be entered at edge t0+N; ready SHALL be high for exactly the cycle after that edge.
REQ-017 In DONE, ready=1 and result = final working value; the next state SHALL be IDLE, or back-to-back acceptance if start=1.
REQ-018 busy SHALL equal (state == SHIFT); ready SHALL equal (state == DONE).
REQ-019 result SHALL be the working register directly; intermediate values are visible but are defined only when ready=1.

Reset
REQ-020 reset low SHALL immediately force state=IDLE, result=0, remaining=0, latched op=0, ready=0, busy=0, including mid-operation; the in-flight operation is discarded with no ready pulse.
REQ-021 After reset release, the first rising edge with start=1 SHALL be accepted.

Configuration
REQ-022 The step-size feature SHALL be controlled by the macro ITER_SHIFTER_STEP4_EN.
REQ-023 With ITER_SHIFTER_STEP4_EN defined, step sizes SHALL be greedy 4/2/1 (4 if remaining >= 4, else 2 if remaining >= 2, else 1); N = shamt/4 + (shamt%4)/2 + shamt%2.
REQ-024 Without ITER_SHIFTER_STEP4_EN, steps SHALL be 2/1 only as in REQ-013; interface and all other behaviour SHALL be identical in both builds.

Structure
REQ-025 Package shift_pkg SHALL hold the state enum (IDLE/SHIFT/DONE), the op encoding constants (OP_SLL=0, OP_SRA=1), and the data width (32) and shamt width (5) constants.
REQ-026 The single-step datapath SHALL be a combinational sub-module shift_step (inputs: value, op, step size; output: shifted value), instantiated once.

Verification
REQ-027 SRA, operand=0x80000000, shamt=2 -> ready one cycle after the single step, result=0xE0000000.
REQ-028 SLL, operand=0x00000001, shamt=31 -> result=0x80000000; ready at t0+16+1 without the macro, t0+9+1 with ITER_SHIFTER_STEP4_EN.
REQ-029 shamt=0, operand=0x1234ABCD, op=SRA -> ready the cycle after acceptance, result=0x1234ABCD, busy never high.
REQ-030 SRA, operand=0x7FFFFFF0, shamt=5 -> result=0x03FFFFFF; start pulse with operand=0xFFFFFFFF during SHIFT -> ignored, result unchanged.
REQ-031 Assert reset low during SHIFT of a shamt=20 operation -> ready, busy and result go to 0 immediately; no ready pulse follows; a new start after release completes correctly.
REQ-032 Back-to-back: start held high in DONE with operand=0x00000003, SLL, shamt=1 -> accepted with no IDLE cycle, ready one step later, result=0x00000006.
